// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by regfile, decode and writeback.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 2;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-producer counters, issue acceptance and operand busy flags.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic              wb_retire_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              issue_ready_o
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DEPTH-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [DEPTH-1:0]            inc, dec;
    logic                        rd_zero, issue_fire, retire;
    logic                        fwd1, fwd2;

    assign rd_zero       = ZERO_REG && (issue_rd_i == '0);
    assign issue_ready_o = rst_ni && ((pend_q[issue_rd_i] != CNT_MAX) || rd_zero);
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign retire        = we_i && wb_retire_i;

    for (genvar r = 0; r < DEPTH; r++) begin : g_cnt
        assign inc[r] = issue_fire && !rd_zero && (issue_rd_i == ADDR_W'(r));
        assign dec[r] = retire && (waddr_i == ADDR_W'(r)) && (pend_q[r] != '0);
    end

    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < DEPTH; r++) begin
            if (inc[r] && !dec[r])      pend_d[r] = pend_q[r] + 1'b1;
            else if (dec[r] && !inc[r]) pend_d[r] = pend_q[r] - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pend_q <= '0;
        else         pend_q <= pend_d;
    end

    // A retire of the last producer is forwarded, so the operand is not busy.
    assign fwd1 = BYPASS && retire && (waddr_i == raddr1_i) && (pend_q[raddr1_i] == CNT_ONE);
    assign fwd2 = BYPASS && retire && (waddr_i == raddr2_i) && (pend_q[raddr2_i] == CNT_ONE);

    assign rs1_busy_o = !(ZERO_REG && raddr1_i == '0) && (pend_q[raddr1_i] != '0) && !fwd1;
    assign rs2_busy_o = !(ZERO_REG && raddr2_i == '0) && (pend_q[raddr2_i] != '0) && !fwd2;
endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write bypass and pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              wb_retire_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    input  logic              issue_valid_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic              issue_ready_o
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic                         wr_en;
    logic                         byp1, byp2;

    assign wr_en = we_i && !(ZERO_REG && waddr_i == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)    mem_q <= '0;
        else if (wr_en) mem_q[waddr_i] <= wdata_i;
    end

    assign byp1 = BYPASS && rst_ni && wr_en && (waddr_i == raddr1_i);
    assign byp2 = BYPASS && rst_ni && wr_en && (waddr_i == raddr2_i);

    assign rdata1_o = (ZERO_REG && raddr1_i == '0) ? '0 : byp1 ? wdata_i : mem_q[raddr1_i];
    assign rdata2_o = (ZERO_REG && raddr2_i == '0) ? '0 : byp2 ? wdata_i : mem_q[raddr2_i];

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wb_retire_i  (wb_retire_i),
        .raddr1_i     (raddr1_i),
        .raddr2_i     (raddr2_i),
        .issue_valid_i(issue_valid_i),
        .issue_rd_i   (issue_rd_i),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .issue_ready_o(issue_ready_o)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: BYPASS=1 and BYPASS=0 instances share stimulus, checked against an array model.
module tb_regfile_sb;
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, ret = 1'b0, iv = 1'b0;
    logic [4:0]  wa = '0, a1 = '0, a2 = '0, rd = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        b1_b, b2_b, b1_n, b2_n, rdy_b, rdy_n;

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1'b1)) u_byp (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(wa), .wdata_i(wd), .wb_retire_i(ret),
        .raddr1_i(a1), .raddr2_i(a2), .rdata1_o(rd1_b), .rdata2_o(rd2_b),
        .rs1_busy_o(b1_b), .rs2_busy_o(b2_b), .issue_valid_i(iv), .issue_rd_i(rd),
        .issue_ready_o(rdy_b));

    regfile_sb #(.BYPASS(1'b0)) u_nob (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(wa), .wdata_i(wd), .wb_retire_i(ret),
        .raddr1_i(a1), .raddr2_i(a2), .rdata1_o(rd1_n), .rdata2_o(rd2_n),
        .rs1_busy_o(b1_n), .rs2_busy_o(b2_n), .issue_valid_i(iv), .issue_rd_i(rd),
        .issue_ready_o(rdy_n));

    typedef struct packed {
        logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
        logic        b1_b, b2_b, b1_n, b2_n, rdy;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m[32];
    int          pend_m[32];
    int          n_tests = 0, n_fail = 0;

    function automatic logic [31:0] m_rdata(bit byp, logic [4:0] a);
        if (a == 0) return 32'h0;
        if (byp && rst_n && we && wa == a) return wd;
        return mem_m[a];
    endfunction

    function automatic logic m_busy(bit byp, logic [4:0] a);
        if (a == 0) return 1'b0;
        if (byp && rst_n && we && ret && wa == a && pend_m[a] == 1) return 1'b0;
        return pend_m[a] != 0;
    endfunction

    task automatic step(input logic r, input logic w, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic rt, input logic [4:0] ra1, input logic [4:0] ra2,
                        input logic ivld, input logic [4:0] ird);
        exp_t e;
        logic ready;
        @(negedge clk);
        #1;
        rst_n = r; we = w; wa = waddr; wd = wdata; ret = rt; a1 = ra1; a2 = ra2; iv = ivld; rd = ird;
        if (!r) begin
            for (int i = 0; i < 32; i++) begin mem_m[i] = '0; pend_m[i] = 0; end
        end
        ready = r && (ird == 0 || pend_m[ird] < MAXC);
        e.rd1_b = m_rdata(1, ra1); e.rd2_b = m_rdata(1, ra2);
        e.rd1_n = m_rdata(0, ra1); e.rd2_n = m_rdata(0, ra2);
        e.b1_b  = m_busy(1, ra1);  e.b2_b  = m_busy(1, ra2);
        e.b1_n  = m_busy(0, ra1);  e.b2_n  = m_busy(0, ra2);
        e.rdy   = ready;
        q.push_back(e);
        if (r) begin
            if (w && waddr != 0) mem_m[waddr] = wdata;
            if (w && rt && pend_m[waddr] > 0) pend_m[waddr]--;
            if (ivld && ready && ird != 0) pend_m[ird]++;
        end
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
        step(1, 0, 0, 0, 0, ra1, ra2, 0, 0);
    endtask

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: samples between the driver update and the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rdata1_byp", rd1_b, e.rd1_b);
                chk("rdata2_byp", rd2_b, e.rd2_b);
                chk("rdata1_nobyp", rd1_n, e.rd1_n);
                chk("rdata2_nobyp", rd2_n, e.rd2_n);
                chk("rs1_busy_byp", 32'(b1_b), 32'(e.b1_b));
                chk("rs2_busy_byp", 32'(b2_b), 32'(e.b2_b));
                chk("rs1_busy_nobyp", 32'(b1_n), 32'(e.b1_n));
                chk("rs2_busy_nobyp", 32'(b2_n), 32'(e.b2_n));
                chk("issue_ready_byp", 32'(rdy_b), 32'(e.rdy));
                chk("issue_ready_nobyp", 32'(rdy_n), 32'(e.rdy));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin mem_m[i] = '0; pend_m[i] = 0; end
        // reset held with a write attempt to reg 4
        repeat (3) step(0, 1, 4, 32'hDEAD, 0, 4, 4, 1, 4);
        idle(4, 4);
        step(1, 0, 0, 0, 0, 4, 0, 1, 4);
        // write and same-cycle bypass
        step(1, 1, 3, 32'h5, 0, 3, 3, 0, 0);
        idle(3, 3);
        // zero register
        step(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
        idle(0, 0);
        // saturate reg 7 (reg 4 already has one producer from above)
        repeat (3) step(1, 0, 0, 0, 0, 7, 7, 1, 7);
        step(1, 0, 0, 0, 0, 7, 7, 1, 7);
        step(1, 1, 7, 32'h77, 1, 7, 7, 1, 7);
        step(1, 0, 0, 0, 0, 7, 7, 1, 7);
        repeat (3) step(1, 1, 7, 32'h70, 1, 7, 7, 0, 0);
        idle(7, 7);
        // simultaneous issue and retire to reg 5
        step(1, 0, 0, 0, 0, 5, 5, 1, 5);
        step(1, 1, 5, 32'hA5, 1, 5, 5, 1, 5);
        idle(5, 5);
        // reset mid-flight with two producers on reg 9
        repeat (2) step(1, 0, 0, 0, 0, 9, 9, 1, 9);
        step(0, 0, 0, 0, 0, 9, 9, 0, 0);
        step(1, 1, 9, 32'h1, 1, 9, 9, 0, 0);
        idle(9, 9);
        // random traffic over a small address window to provoke hazards
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 99) != 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)));
        end
        @(negedge clk);
        #5;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
